// File: rtl/shapool_result_if.sv
// Result handshake bundle between shapool_result (master) and its consumer (slave).
interface shapool_result_if;
  logic        result_valid;
  logic        result_ready;
  logic        result_found;
  logic [31:0] result_nonce;
  logic [7:0]  result_match_flags;

  modport master (
    output result_valid, result_found, result_nonce, result_match_flags,
    input  result_ready
  );

  modport slave (
    input  result_valid, result_found, result_nonce, result_match_flags,
    output result_ready
  );
endinterface

// File: rtl/shapool_result.sv
// Job control and result capture for the hashing pool: releases the pool on start,
// tracks its 64-cycle round timing, samples success at check slots and reports the nonce.
module shapool_result #(
  parameter int unsigned POOL_SIZE         = 2,
  parameter int unsigned POOL_SIZE_LOG2    = 1,
  parameter int unsigned NONCE_LAG         = 2,
  parameter int unsigned CHECK_COUNT_WIDTH = 32 - POOL_SIZE_LOG2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  nonce_start_MSB,
  output logic        pool_reset_n,
  output logic [7:0]  pool_nonce_start_MSB,
  input  logic        pool_success,
  input  logic [31:0] pool_nonce,
  input  logic [7:0]  pool_match_flags,
  output logic        busy,
  shapool_result_if.master res
);

  localparam int unsigned LOW_W = 32 - POOL_SIZE_LOG2;

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t                         state;
  logic [5:0]                     phase;
  logic [1:0]                     pass;
  logic [CHECK_COUNT_WIDTH-1:0]   check_cnt;

  logic [POOL_SIZE_LOG2-1:0]      hit_idx;
  logic [LOW_W-1:0]               low;
  logic [31:0]                    hit_nonce;
  logic                           check_slot;

  // Lowest-numbered matching pipeline wins; scan downwards so the last write is the lowest.
  always_comb begin
    hit_idx = '0;
    for (int unsigned i = POOL_SIZE; i > 0; i--) begin
      if (pool_match_flags[3'(i - 1)]) hit_idx = POOL_SIZE_LOG2'(i - 1);
    end
  end

  // The pool's nonce runs NONCE_LAG ahead of the one under test; its top byte was seeded by the MSB XOR.
  always_comb begin
    low        = pool_nonce[LOW_W-1:0] - LOW_W'(NONCE_LAG);
    hit_nonce  = {hit_idx, low[LOW_W-1 -: 8] ^ pool_nonce_start_MSB, low[LOW_W-9:0]};
    check_slot = (phase == '0) && (pass == 2'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      pool_reset_n           <= 1'b0;
      pool_nonce_start_MSB   <= '0;
      busy                   <= 1'b0;
      res.result_valid       <= 1'b0;
      res.result_found       <= 1'b0;
      res.result_nonce       <= '0;
      res.result_match_flags <= '0;
      phase                  <= '0;
      pass                   <= '0;
      check_cnt              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pool_nonce_start_MSB <= nonce_start_MSB;
            phase                <= '0;
            pass                 <= '0;
            check_cnt            <= '0;
            pool_reset_n         <= 1'b1;
            busy                 <= 1'b1;
            state                <= RUN;
          end
        end

        RUN: begin
          phase <= phase + 1'b1;
          if (phase == '1 && pass != 2'd2) pass <= pass + 1'b1;

          if (abort) begin
            pool_reset_n <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else if (check_slot) begin
            if (pool_success) begin
              res.result_found       <= 1'b1;
              res.result_nonce       <= hit_nonce;
              res.result_match_flags <= pool_match_flags;
              res.result_valid       <= 1'b1;
              pool_reset_n           <= 1'b0;
              state                  <= REPORT;
            end else begin
              check_cnt <= check_cnt + 1'b1;
              if (&check_cnt) begin
                res.result_found       <= 1'b0;
                res.result_nonce       <= '0;
                res.result_match_flags <= '0;
                res.result_valid       <= 1'b1;
                pool_reset_n           <= 1'b0;
                state                  <= REPORT;
              end
            end
          end
        end

        REPORT: begin
          if (res.result_ready) begin
            res.result_valid <= 1'b0;
            busy             <= 1'b0;
            state            <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shapool_result.sv
// Directed bench for shapool_result with a slot-arithmetic reference model checked every cycle.
module tb_shapool_result;

  localparam int POOL_SIZE      = 2;
  localparam int POOL_SIZE_LOG2 = 1;
  localparam int NONCE_LAG      = 2;
  localparam int CCW            = 2;
  localparam int NSLOTS         = 1 << CCW;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  nonce_start_MSB = '0;
  logic        pool_reset_n;
  logic [7:0]  pool_nonce_start_MSB;
  logic        pool_success = 1'b0;
  logic [31:0] pool_nonce = '0;
  logic [7:0]  pool_match_flags = '0;
  logic        busy;

  shapool_result_if res_if ();

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shapool_result #(
    .POOL_SIZE         (POOL_SIZE),
    .POOL_SIZE_LOG2    (POOL_SIZE_LOG2),
    .NONCE_LAG         (NONCE_LAG),
    .CHECK_COUNT_WIDTH (CCW)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .abort                (abort),
    .nonce_start_MSB      (nonce_start_MSB),
    .pool_reset_n         (pool_reset_n),
    .pool_nonce_start_MSB (pool_nonce_start_MSB),
    .pool_success         (pool_success),
    .pool_nonce           (pool_nonce),
    .pool_match_flags     (pool_match_flags),
    .busy                 (busy),
    .res                  (res_if.master)
  );

  // Reference model: job progress is tracked as elapsed cycles since RUN entry.
  logic        m_run = 1'b0;
  logic        m_rep = 1'b0;
  int          m_k = 0;
  logic [7:0]  m_msb = '0;
  logic        m_found = 1'b0;
  logic [31:0] m_nonce = '0;
  logic [7:0]  m_flags = '0;

  function automatic logic [31:0] exp_nonce(input logic [7:0] msb, input logic [7:0] flags,
                                            input logic [31:0] pn);
    int     idx = 0;
    int     lw  = 32 - POOL_SIZE_LOG2;
    longint low;
    for (int i = POOL_SIZE - 1; i >= 0; i--) if (flags[i]) idx = i;
    low = (longint'(pn) - NONCE_LAG) & ((longint'(1) << lw) - 1);
    return 32'((longint'(idx) << lw) | (low ^ (longint'(msb) << (lw - 8))));
  endfunction

  function automatic bit is_slot(input int k);
    return (k >= 128) && ((k - 128) % 64 == 0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run <= 1'b0; m_rep <= 1'b0; m_k <= 0; m_msb <= '0;
      m_found <= 1'b0; m_nonce <= '0; m_flags <= '0;
    end else if (m_rep) begin
      if (res_if.result_ready) m_rep <= 1'b0;
    end else if (m_run) begin
      m_k <= m_k + 1;
      if (abort) begin
        m_run <= 1'b0;
      end else if (is_slot(m_k)) begin
        if (pool_success) begin
          m_run <= 1'b0; m_rep <= 1'b1; m_found <= 1'b1;
          m_nonce <= exp_nonce(m_msb, pool_match_flags, pool_nonce);
          m_flags <= pool_match_flags;
        end else if ((m_k - 128) / 64 == NSLOTS - 1) begin
          m_run <= 1'b0; m_rep <= 1'b1; m_found <= 1'b0;
          m_nonce <= '0; m_flags <= '0;
        end
      end
    end else if (start) begin
      m_run <= 1'b1; m_k <= 0; m_msb <= nonce_start_MSB;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy",         32'(busy),                     32'(m_run | m_rep));
    chk("pool_reset_n", 32'(pool_reset_n),             32'(m_run));
    chk("pool_msb",     32'(pool_nonce_start_MSB),     32'(m_msb));
    chk("valid",        32'(res_if.result_valid),      32'(m_rep));
    chk("found",        32'(res_if.result_found),      32'(m_found));
    chk("nonce",        res_if.result_nonce,           m_nonce);
    chk("flags",        32'(res_if.result_match_flags), 32'(m_flags));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_job(input logic [7:0] msb);
    nonce_start_MSB = msb;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic hit(input logic [7:0] flags, input logic [31:0] pn);
    pool_success = 1'b1; pool_match_flags = flags; pool_nonce = pn;
    tick(1);
    pool_success = 1'b0;
  endtask

  task automatic consume();
    res_if.result_ready = 1'b1;
    tick(1);
    res_if.result_ready = 1'b0;
  endtask

  initial begin
    res_if.result_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_pool_reset_n", 32'(pool_reset_n), 32'd0);
    chk("rst_busy",         32'(busy),         32'd0);
    chk("rst_valid",        32'(res_if.result_valid), 32'd0);
    #20 reset_n = 1'b1;
    tick(1);

    // Hit on the third slot, with off-slot success pulses that must be ignored
    start_job(8'h00);
    tick(5);
    hit(8'h01, 32'h0000_0010);          // phase 5
    tick(58);
    hit(8'h01, 32'h0000_0010);          // phase 0, pass 1
    chk("offslot_busy",  32'(busy), 32'd1);
    chk("offslot_valid", 32'(res_if.result_valid), 32'd0);
    tick(191);
    chk("pre_hit_valid", 32'(res_if.result_valid), 32'd0);
    hit(8'h02, 32'h0000_0004);          // cycle 256
    chk("t1_valid", 32'(res_if.result_valid), 32'd1);
    chk("t1_found", 32'(res_if.result_found), 32'd1);
    chk("t1_nonce", res_if.result_nonce, 32'h8000_0002);
    chk("t1_flags", 32'(res_if.result_match_flags), 32'h02);

    // Back-pressure: result held, start ignored
    tick(4);
    start_job(8'hFF);
    tick(5);
    chk("hold_nonce", res_if.result_nonce, 32'h8000_0002);
    chk("hold_msb",   32'(pool_nonce_start_MSB), 32'h00);
    chk("hold_valid", 32'(res_if.result_valid), 32'd1);
    consume();
    chk("post_ack_valid", 32'(res_if.result_valid), 32'd0);
    chk("post_ack_busy",  32'(busy), 32'd0);

    // XOR seed and lowest-index priority
    start_job(8'hA5);
    chk("t2_msb",  32'(pool_nonce_start_MSB), 32'hA5);
    chk("t2_prst", 32'(pool_reset_n), 32'd1);
    tick(128);
    hit(8'h03, 32'h0000_0002);
    chk("t2_nonce", res_if.result_nonce, 32'h5280_0000);
    chk("t2_flags", 32'(res_if.result_match_flags), 32'h03);
    consume();

    // Exhaustion after the fourth slot
    start_job(8'h00);
    tick(320);
    chk("ex_pre_valid", 32'(res_if.result_valid), 32'd0);
    tick(1);
    chk("ex_valid", 32'(res_if.result_valid), 32'd1);
    chk("ex_found", 32'(res_if.result_found), 32'd0);
    chk("ex_nonce", res_if.result_nonce, 32'd0);
    chk("ex_flags", 32'(res_if.result_match_flags), 32'd0);
    consume();

    // Hit on the final slot beats exhaustion
    start_job(8'h3C);
    tick(320);
    hit(8'h01, 32'h0000_0010);
    chk("last_found", 32'(res_if.result_found), 32'd1);
    chk("last_nonce", res_if.result_nonce, 32'h1E00_000E);
    consume();

    // start and abort together in IDLE: start wins; later abort in RUN
    abort = 1'b1;
    start_job(8'h11);
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd1);
    tick(50);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_prst", 32'(pool_reset_n), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    tick(200);
    chk("abort_valid", 32'(res_if.result_valid), 32'd0);

    // Abort on a hit slot discards the hit
    start_job(8'h22);
    tick(128);
    abort = 1'b1;
    hit(8'h01, 32'h0000_0100);
    abort = 1'b0;
    chk("ahit_valid", 32'(res_if.result_valid), 32'd0);
    chk("ahit_busy",  32'(busy), 32'd0);

    // Asynchronous reset mid-RUN
    start_job(8'h77);
    tick(30);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_prst", 32'(pool_reset_n), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_msb",  32'(pool_nonce_start_MSB), 32'd0);
    #2 reset_n = 1'b1;
    tick(3);
    chk("arst_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shapool_result.md
Name: shapool_result

Overview:
- Job-control and result-capture stage that sits directly downstream of the hashing pool. It also owns the pool's reset and its nonce_start_MSB input.
- On a start pulse it releases the pool and mirrors the pool's 64-cycle round timing. At each valid check slot it samples the pool's success flag.
- On a hit it reconstructs the full 32-bit winning nonce and presents it through a valid/ready handshake.
- It reports exhaustion if the nonce space completes without a hit.

Parameters:
POOL_SIZE, 2, number of pipelines in the pool (power of 2, max 8)
POOL_SIZE_LOG2, 1, log2(POOL_SIZE), must be >= 1
NONCE_LAG, 2, difference between pool nonce output and the nonce under test at a check slot
CHECK_COUNT_WIDTH, 32-POOL_SIZE_LOG2, check slots per job = 2^CHECK_COUNT_WIDTH (bench overrides to a small value)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle job start pulse
abort  in  1  one-cycle job cancel pulse
nonce_start_MSB  in  8  job nonce MSB seed, captured on accepted start
pool_reset_n  out  1  drives pool reset_n (pool reset is synchronous)
pool_nonce_start_MSB  out  8  registered seed to the pool
pool_success  in  1  pool success flag
pool_nonce  in  32  pool nonce output ({0.., nonce_lower})
pool_match_flags  in  8  pool per-pipeline match flags
busy  out  1  high in RUN or REPORT
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_found  out  1  1 = nonce found, 0 = space exhausted
result_nonce  out  32  winning nonce (0 when exhausted)
result_match_flags  out  8  match_flags captured at the hit (0 when exhausted)

Behaviour:
- Async reset: state=IDLE, pool_reset_n=0, pool_nonce_start_MSB=0, busy=0, result_valid=0, result_found=0, result_nonce=0, result_match_flags=0, phase=0, pass=0, check_cnt=0.
- FSM states: IDLE, RUN, REPORT. All outputs are registered.
- IDLE:
  - pool_reset_n=0.
  - start=1: capture nonce_start_MSB into pool_nonce_start_MSB, clear phase/pass/check_cnt, and on the same edge go to RUN with pool_reset_n=1.
- RUN:
  - The first RUN cycle has phase=0, matching pool round=0. phase is a 6-bit counter that increments every cycle and wraps 63->0.
  - pass is a 2-bit counter that saturates at 2 and increments on each phase 63->0 wrap.
  - Check slot = (phase==0 && pass==2). The first check slot falls 128 cycles after RUN entry, then one every 64 cycles.
  - Outside check slots, pool_success is ignored.
- Check slot with pool_success=1:
  - idx = lowest set bit of pool_match_flags[POOL_SIZE-1:0].
  - low = (pool_nonce[31-POOL_SIZE_LOG2:0] - NONCE_LAG), modulo 2^(32-POOL_SIZE_LOG2).
  - result_nonce = {idx[POOL_SIZE_LOG2-1:0], low[top 8 bits] ^ nonce_start_MSB, low[remaining bits]}.
  - result_match_flags = pool_match_flags; result_found=1.
  - Go to REPORT.
- Check slot with pool_success=0:
  - check_cnt increments.
  - If check_cnt was already all-ones (final slot): result_found=0, result_nonce=0, result_match_flags=0, go to REPORT.
  - A hit on the final slot takes priority over exhaustion.
- REPORT:
  - pool_reset_n=0, result_valid=1, result fields stable.
  - On result_valid && result_ready: result_valid=0, go to IDLE next cycle.
  - The result fields keep their values until the next capture.
- busy=1 in RUN and REPORT.
- start in RUN or REPORT is ignored.
- abort:
  - In RUN: go to IDLE, pool_reset_n=0, no result produced.
  - In REPORT: abort is ignored; the result must be consumed.
  - abort and start together in IDLE: start wins.
  - abort on a RUN check slot that has a hit: abort wins and the hit is discarded.
- Async reset in any state returns immediately to the reset values; a pending result is lost.
- pool_reset_n is held low for at least one cycle between consecutive jobs, because IDLE always lasts at least one cycle.

Test Plan:
1. Hit: reset, start with nonce_start_MSB=0x00. At the 3rd check slot (cycle 256 after RUN entry) drive pool_success=1, pool_match_flags=0x02, pool_nonce=0x00000004 -> result_valid=1 one cycle later, result_found=1, result_nonce=0x80000002, result_match_flags=0x02.
2. XOR and priority: nonce_start_MSB=0xA5, hit with pool_match_flags=0x03, pool_nonce=0x00000002 -> result_nonce=0x52800000 (idx=0; top 8 bits of the 31-bit lower field = 0x00^0xA5, so bits 30:23 = 0xA5); result_match_flags=0x03.
3. Off-slot ignore: assert pool_success at phase 5 and at phase 0 during pass<2 -> no capture, state stays RUN.
4. Exhaustion: CHECK_COUNT_WIDTH=2, never assert success -> result_valid after the 4th check slot (cycle 320), result_found=0, result_nonce=0. In a second run, assert a hit on the 4th slot -> result_found=1.
5. Handshake and abort: hold result_ready=0 for 10 cycles -> result stays stable and a start during that time is ignored; pulse ready -> IDLE, then a new start is accepted. In a separate job, pulse abort in RUN -> pool_reset_n=0 the next cycle and no result_valid.
6. Async reset: assert reset_n=0 mid-RUN between clock edges -> pool_reset_n=0 and busy=0 immediately without waiting for a clock edge.
